// File: rtl/tbuart_pkg.sv
// tbuart_pkg: shared definitions for the 8N1 transmit UART.
//   tx_state_t   - 2-bit FSM encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   DATA_BITS    - payload bits per frame
//   FRAME_BITS   - start + data + stop
//   frame_cycles - clock cycles occupied by one frame at a given divider
package tbuart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int frame_cycles(input int clk_div);
        return FRAME_BITS * clk_div;
    endfunction

endpackage

// File: rtl/tbuart_fifo.sv
// tbuart_fifo: synchronous FIFO feeding the UART shifter.
//   clk, reset  - clock, synchronous active-high reset (pointers/level only)
//   push, wdata - write request; ignored while full
//   pop, rdata  - read request; rdata shows the oldest entry (first-word fall-through)
//   level       - number of stored entries, 0..DEPTH
//   full        - level == DEPTH, straight from the registered level
module tbuart_fifo
    import tbuart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (level != '0);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (do_push && !reset)
            mem[wr_ptr] <= wdata;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tbuart_tx.sv
// tbuart_tx: 8N1 UART transmitter with input FIFO, back-to-back framing.
//   clk        - sole clock
//   reset      - synchronous active-high; aborts any frame, drops queued bytes
//   in_valid   - in_data holds a byte to send
//   in_data    - byte to transmit
//   in_ready   - FIFO not full; transfer on in_valid & in_ready
//   ser_tx     - registered serial line, idle high
//   busy       - a frame is on the line
//   fifo_level - queued bytes, not counting the one in the shifter
module tbuart_tx
    import tbuart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [7:0]                  in_data,
    output logic                        in_ready,
    output logic                        ser_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int            CW         = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(CLK_DIV - 1);
    localparam logic [2:0]    LAST_BIT   = 3'(DATA_BITS - 1);

    tx_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [7:0]    shf, shf_nxt;
    logic          tx_nxt;
    logic          pop;
    logic          fifo_full;
    logic [7:0]    fifo_rdata;

    assign in_ready = ~fifo_full;
    assign busy     = (state != ST_IDLE);

    tbuart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid & in_ready),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shf    <= '0;
            ser_tx <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shf    <= shf_nxt;
            ser_tx <= tx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shf_nxt   = shf;
        pop       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    shf_nxt   = fifo_rdata;
                    cnt_nxt   = CNT_RELOAD;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (cnt == '0) begin
                    cnt_nxt   = CNT_RELOAD;
                    idx_nxt   = '0;
                    state_nxt = ST_DATA;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == '0) begin
                    shf_nxt = {1'b0, shf[7:1]};
                    cnt_nxt = CNT_RELOAD;
                    if (idx == LAST_BIT)
                        state_nxt = ST_STOP;
                    else
                        idx_nxt = idx + 3'd1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt == '0) begin
                    // Chain straight into the next start bit when a byte is
                    // waiting, so queued frames leave no idle gap.
                    if (fifo_level != '0) begin
                        pop       = 1'b1;
                        shf_nxt   = fifo_rdata;
                        cnt_nxt   = CNT_RELOAD;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Line level is decided from the post-edge state and shifter so the
    // registered output lines up with the state it belongs to.
    always_comb begin
        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shf_nxt[0];
            default:  tx_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tbuart_tx.sv
module tb_tbuart_tx;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int MAXB  = 512;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        vld;
    logic [N-1:0][7:0]   dat;
    logic [N-1:0]        rdy, tx, bsy;
    logic [N-1:0][2:0]   lvl;

    always #5 clk = ~clk;

    tbuart_tx #(.CLK_DIV(4), .FIFO_DEPTH(DEPTH)) u_d4 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy[0]), .ser_tx(tx[0]), .busy(bsy[0]), .fifo_level(lvl[0]));
    tbuart_tx #(.CLK_DIV(2), .FIFO_DEPTH(DEPTH)) u_d2 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(dat[1]),
        .in_ready(rdy[1]), .ser_tx(tx[1]), .busy(bsy[1]), .fifo_level(lvl[1]));
    tbuart_tx #(.CLK_DIV(7), .FIFO_DEPTH(DEPTH)) u_d7 (
        .clk(clk), .reset(reset), .in_valid(vld[2]), .in_data(dat[2]),
        .in_ready(rdy[2]), .ser_tx(tx[2]), .busy(bsy[2]), .fifo_level(lvl[2]));

    // Reference model: each accepted byte gets a frame start time on a
    // line schedule; the line is a pure function of that schedule.
    int         acc_t [N][MAXB];
    int         st_t  [N][MAXB];
    logic [7:0] dq    [N][MAXB];
    int         na        [N];
    int         line_free [N];

    logic [7:0] src [N][1024];
    int         src_wr [N];
    int         src_rd [N];
    logic [N-1:0] last_acc;
    bit         gaps;
    int         cyc;
    int         tests;
    int         fails;
    int         bcnt [N];

    function automatic int dv(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 7;
        endcase
    endfunction

    // queued = accepted by edge t but whose frame has not started yet
    function automatic int m_level(input int k, input int t);
        int c;
        c = 0;
        for (int i = 0; i < na[k]; i++)
            if (acc_t[k][i] <= t && st_t[k][i] > t) c++;
        return c;
    endfunction

    function automatic void m_line(input int k, input int t, output logic l, output logic b);
        int d;
        int bn;
        d = dv(k);
        l = 1'b1;
        b = 1'b0;
        for (int i = 0; i < na[k]; i++) begin
            if (t >= st_t[k][i] && t < st_t[k][i] + 10 * d) begin
                bn = (t - st_t[k][i]) / d;
                b  = 1'b1;
                if (bn == 0)      l = 1'b0;
                else if (bn == 9) l = 1'b1;
                else              l = dq[k][i][bn-1];
            end
        end
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", tag, k, cyc, got, want);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b);
        src[k][src_wr[k]] = b;
        src_wr[k]++;
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (vld[k] && !last_acc[k]) continue;
            if (src_rd[k] != src_wr[k] && (!gaps || $urandom_range(0, 2) != 0)) begin
                vld[k] = 1'b1;
                dat[k] = src[k][src_rd[k]];
            end else begin
                vld[k] = 1'b0;
                dat[k] = 8'h00;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] a;
        logic el, eb;
        int s;
        drive();
        for (int k = 0; k < N; k++)
            a[k] = vld[k] && !reset && (m_level(k, cyc) != DEPTH);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                na[k]        = 0;
                line_free[k] = 0;
            end else if (a[k]) begin
                s = (cyc + 1 > line_free[k]) ? cyc + 1 : line_free[k];
                acc_t[k][na[k]] = cyc;
                st_t[k][na[k]]  = s;
                dq[k][na[k]]    = dat[k];
                na[k]++;
                line_free[k] = s + 10 * dv(k);
                src_rd[k]++;
            end
        end
        last_acc = a;
        #1;
        for (int k = 0; k < N; k++) begin
            m_line(k, cyc, el, eb);
            chk("ser_tx", k, tx[k], el);
            chk("busy", k, bsy[k], eb);
            chk("fifo_level", k, lvl[k], m_level(k, cyc));
            chk("in_ready", k, rdy[k], m_level(k, cyc) != DEPTH);
            if (bsy[k]) bcnt[k]++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int e;
        int budget;
        bit done;
        reset = 1'b1; vld = '0; dat = '0; gaps = 0; cyc = 0;
        tests = 0; fails = 0; last_acc = '0;
        for (int k = 0; k < N; k++) begin
            na[k] = 0; line_free[k] = 0; src_wr[k] = 0; src_rd[k] = 0; bcnt[k] = 0;
        end
        run(3);
        reset = 1'b0;
        chk("rst_tx", 0, tx[0], 1);
        chk("rst_busy", 0, bsy[0], 0);
        chk("rst_level", 0, lvl[0], 0);
        chk("rst_ready", 0, rdy[0], 1);

        // single byte 0x55 on every divider
        for (int k = 0; k < N; k++) begin push(k, 8'h55); bcnt[k] = 0; end
        run(80);
        for (int k = 0; k < N; k++) chk("single_busy_len", k, bcnt[k], 10 * dv(k));

        // back-to-back frames
        bcnt[0] = 0;
        push(0, 8'hA5); push(0, 8'h3C);
        run(90);
        chk("b2b_busy_len", 0, bcnt[0], 80);

        // divider sweep with MSB set
        for (int k = 0; k < N; k++) begin push(k, 8'h80); bcnt[k] = 0; end
        run(80);
        for (int k = 0; k < N; k++) chk("sweep_busy_len", k, bcnt[k], 10 * dv(k));

        // full FIFO under held valid
        for (int b = 1; b <= 7; b++) push(0, 8'(b));
        run(300);

        // push coinciding with the STOP->START pop at level 2
        e = cyc + 1;
        push(0, 8'hC1); push(0, 8'h5E); push(0, 8'h0F);
        run(3);
        while (cyc < e + 40) tick();
        push(0, 8'hB2);
        tick();
        chk("simul_level", 0, lvl[0], 2);
        run(130);

        // reset during data bit 3 with two bytes queued
        e = cyc + 1;
        push(0, 8'h96); push(0, 8'h11); push(0, 8'h22);
        while (cyc < e + 18) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tx", 0, tx[0], 1);
        chk("midrst_busy", 0, bsy[0], 0);
        chk("midrst_level", 0, lvl[0], 0);
        bcnt[0] = 0;
        push(0, 8'hFF);
        run(50);
        chk("post_rst_busy_len", 0, bcnt[0], 40);

        // random traffic with random valid gaps
        gaps = 1;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 40; i++) push(k, 8'($urandom));
        budget = 8000;
        done = 0;
        while (!done && budget > 0) begin
            tick();
            budget--;
            done = 1;
            for (int k = 0; k < N; k++)
                if (src_rd[k] != src_wr[k] || line_free[k] > cyc) done = 0;
        end
        for (int k = 0; k < N; k++) chk("random_drained", k, src_rd[k], src_wr[k]);
        run(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
